// File: rtl/serial_word_adder_pkg.sv
// Shared definitions for the serial word adder.
//
// Contents:
//   BYTE_W    - datapath width of one operand byte
//   state_e   - word-position state: FIRST (next byte is a word's LSB) or MID
//   idx_width - byte-index width for a given maximum word length (never below 1)
package serial_word_adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    FIRST = 1'b0,
    MID   = 1'b1
  } state_e;

  // clog2 collapses to 0 for a 1-byte maximum; keep the index port at least 1 bit wide.
  function automatic int unsigned idx_width(input int unsigned max_bytes);
    return (max_bytes > 1) ? $clog2(max_bytes) : 1;
  endfunction

endpackage

// File: rtl/serial_word_adder_adding_bytes.sv
// 8-bit ripple carry adder used by the serial word adder (the AddingBytes block).
//
// Ports:
//   a, b  in  BYTE_W  operand bytes
//   cin   in  1       carry into bit 0
//   sum   out BYTE_W  (a + b + cin) mod 2^BYTE_W
//   cout  out 1       carry out of the top bit
module serial_word_adder_adding_bytes
  import serial_word_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign sum  = full[BYTE_W-1:0];
  assign cout = full[BYTE_W];

endmodule

// File: rtl/serial_word_adder.sv
// Byte-serial multi-byte adder/subtractor.
//
// Operands arrive one byte pair per cycle, least-significant byte first, with in_last marking
// the most-significant byte. Each accepted pair produces one result byte one cycle later in a
// single output register; throughput is one byte per cycle. The add/subtract mode is taken from
// in_sub on the first byte of a word and held for the rest of it. On the last byte the word's
// carry-out, signed overflow and all-zero flags are reported; on other bytes they read 0.
//
// Parameters:
//   MAX_BYTES  maximum word length in bytes; out_idx wraps modulo MAX_BYTES
//   IW         width of out_idx (derived)
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       operand byte pair present
//   in_ready   out  1       pair accepted this cycle when in_valid is also high
//   in_x       in   8       operand X byte
//   in_y       in   8       operand Y byte
//   in_sub     in   1       1 = X-Y, 0 = X+Y (first byte of a word only)
//   in_last    in   1       most-significant byte of the word
//   out_valid  out  1       result byte present
//   out_ready  in   1       downstream takes the result byte
//   out_sum    out  8       result byte
//   out_idx    out  IW      byte position of out_sum in its word
//   out_last   out  1       out_sum is the word's MSB
//   out_carry  out  1       carry out of the MSB (subtract: 1 = no borrow), last byte only
//   out_ovf    out  1       signed overflow of the word, last byte only
//   out_zero   out  1       every result byte of the word was zero, last byte only
module serial_word_adder
  import serial_word_adder_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 16,
  localparam int unsigned IW       = idx_width(MAX_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_x,
  input  logic [BYTE_W-1:0] in_y,
  input  logic              in_sub,
  input  logic              in_last,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_sum,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_zero
);

  // Word-progress state
  state_e            state_q;
  logic              mode_q;      // latched subtract mode for the current word
  logic              carry_q;     // carry between bytes
  logic              zero_acc_q;  // all bytes so far were zero
  logic [IW-1:0]     idx_q;       // position of the next byte

  // Output register
  logic              out_valid_q;
  logic [BYTE_W-1:0] out_sum_q;
  logic [IW-1:0]     out_idx_q;
  logic              out_last_q;
  logic              out_carry_q;
  logic              out_ovf_q;
  logic              out_zero_q;

  // Per-byte datapath
  logic              first;
  logic              accept;
  logic              mode;
  logic              cin;
  logic [BYTE_W-1:0] eff_y;
  logic [BYTE_W-1:0] sum;
  logic              cout;
  logic              c7;
  logic              ovf;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_next;
  logic              zero_next;

  // A pop frees the output register in the same cycle, so a new byte may replace it.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    first = (state_q == FIRST);
    // Subtraction is X + ~Y + 1: the +1 enters as carry-in on the word's first byte.
    mode  = first ? in_sub : mode_q;
    cin   = first ? in_sub : carry_q;
    eff_y = in_y ^ {BYTE_W{mode}};
    idx   = first ? '0 : idx_q;
    if (idx == IW'(MAX_BYTES - 1)) begin
      idx_next = '0;
    end else begin
      idx_next = idx + IW'(1);
    end
    zero_next = (first || zero_acc_q) && (sum == '0);
    // Carry into bit 7 recovered from the sum bit; overflow is that XOR the carry out of bit 7.
    c7  = in_x[BYTE_W-1] ^ eff_y[BYTE_W-1] ^ sum[BYTE_W-1];
    ovf = c7 ^ cout;
  end

  serial_word_adder_adding_bytes u_adding_bytes (
    .a    (in_x),
    .b    (eff_y),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FIRST;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      zero_acc_q  <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (accept) begin
      state_q     <= in_last ? FIRST : MID;
      mode_q      <= mode;
      carry_q     <= cout;
      zero_acc_q  <= zero_next;
      idx_q       <= idx_next;
      out_valid_q <= 1'b1;
      out_sum_q   <= sum;
      out_idx_q   <= idx;
      out_last_q  <= in_last;
      out_carry_q <= in_last && cout;
      out_ovf_q   <= in_last && ovf;
      out_zero_q  <= in_last && zero_next;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule
